rect_frame_scheduler: RTL and testbench
=======================================

Name: rect_frame_scheduler

Overview:
- Sequences one rectangle-table copy per video frame from the shared data memory into GPU rect memory.
- On each vsync rising edge it stalls the CPU and takes over the single data-memory read port for the copier.
- It fires the copier's one-cycle start pulse, generates GPU write enable/address for every copied word, then releases the port and signals frame completion.
- Sits between CPU, data memory, rect copier and GPU rect RAM.

Parameters:
- ADDR_WIDTH, 13, data-memory address width.
- RECT_COUNT, 64, rectangles per frame.
- WORDS_PER_RECT, 6, words per rectangle record (abs, x, y, w, h, color).
- GPU_ADDR_WIDTH, 9, GPU rect-RAM write address width; must hold RECT_COUNT*WORDS_PER_RECT-1.
- OVR_WIDTH, 8, width of the overrun counter.
- STALL_TIMEOUT, 255, ack-wait limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sched_en  in  1  enables frame triggering; sampled only in IDLE.
- vsync  in  1  frame sync, synchronous to clk.
- cpu_stall  out  1  request for the CPU to freeze memory access.
- cpu_stall_ack  in  1  CPU is frozen.
- cpu_rd_addr  in  ADDR_WIDTH  CPU data-memory read address.
- copier_rd_addr  in  ADDR_WIDTH  copier data-memory read address.
- mem_rd_addr  out  ADDR_WIDTH  muxed address to the data memory.
- copy_start  out  1  one-cycle start pulse to the copier.
- gpu_we  out  1  GPU rect-RAM write enable (data comes straight from the copier).
- gpu_waddr  out  GPU_ADDR_WIDTH  GPU rect-RAM write address.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse on completion.
- overrun_cnt  out  OVR_WIDTH  count of dropped vsync edges.
- stall_timeout  out  1  sticky error flag (optional feature only, else tied 0).

Behaviour:
- Reset: state=IDLE; all outputs 0; the vsync edge-detect register is cleared.
- vsync edge: vs_q <= vsync each cycle; edge = vsync & ~vs_q.
- Constant: COPY_CYCLES = RECT_COUNT*WORDS_PER_RECT (384 at defaults).
- IDLE:
  - edge & sched_en: go to STALL, assert cpu_stall from the next cycle.
  - Edge with sched_en=0: ignored; no counting.
- STALL:
  - cpu_stall=1.
  - cpu_stall_ack=1: go to START. Ack already high on entry still takes one cycle in STALL.
- START (1 cycle):
  - copy_start=1; grant=1; word counter cnt cleared to 0.
- COPY:
  - grant=1; gpu_we=1; gpu_waddr=cnt; cnt increments every cycle.
  - Copier output word N appears on cycle N+1 after copy_start.
  - The cycle with cnt==COPY_CYCLES-1 is the last write; next state is DONE.
- DONE (1 cycle):
  - grant=0; cpu_stall=0; gpu_we=0; frame_done=1; next state IDLE.
- Address mux: mem_rd_addr = grant ? copier_rd_addr : cpu_rd_addr. Purely combinational from the registered grant.
- cpu_stall stays high from STALL through DONE's preceding cycle. It drops in DONE, so the CPU never sees the copier address.
- Overrun: a vsync edge while busy is dropped (never queued). overrun_cnt increments and saturates at all-ones. Counting does not depend on sched_en.
- sched_en deasserted mid-frame: the current frame completes normally.
- Simultaneous DONE and edge: that edge counts as an overrun (busy is still 1).
- Async reset mid-copy:
  - Immediately returns to IDLE, grant=0.
  - The CPU is released with no frame_done pulse.
  - The copier has its own reset and is not driven by this block.
- Width: cnt is GPU_ADDR_WIDTH wide. gpu_waddr never reaches COPY_CYCLES.

Optional Feature:
- Macro: RECT_SCHED_STALL_TIMEOUT_EN.
- With the macro:
  - A wait counter runs in STALL.
  - If ack is still absent after STALL_TIMEOUT cycles: drop cpu_stall, set stall_timeout (sticky until reset), return to IDLE with no copy_start and no frame_done.
- Without the macro: STALL waits indefinitely; stall_timeout is tied to 0.

Decomposition:
- Shared package rect_pkg holds:
  - RECT_COUNT, WORDS_PER_RECT, COPY_CYCLES;
  - the rect table base (8192-6*64);
  - the scheduler state enum (IDLE, STALL, START, COPY, DONE).
- One natural sub-module: rect_sched_edge_ovr, holding the vsync edge detector and saturating overrun counter.
- The FSM, address mux and write counter stay in the top module.

Test Plan:
- Basic frame: sched_en=1; vsync rises; ack 3 cycles after cpu_stall.
  - Expect copy_start one cycle after ack.
  - Expect gpu_we for exactly 384 cycles with gpu_waddr 0..383.
  - Expect frame_done one cycle after waddr 383, then cpu_stall=0.
- Mux check: cpu_rd_addr=0x0100, copier_rd_addr=0x1E80.
  - Expect mem_rd_addr=0x0100 in IDLE/STALL/DONE and 0x1E80 in START/COPY.
- Overrun: 3 vsync edges during COPY → overrun_cnt=3 and no extra frame. 300 edges over busy frames → saturates at 255.
- Disable: sched_en=0 at vsync → stays IDLE. sched_en dropped at cnt=100 → frame finishes to 383.
- Reset mid-COPY at cnt=50: asserting reset (low) forces all outputs to 0 and state IDLE asynchronously, with no frame_done pulse. The next vsync after release runs a full frame.
- With RECT_SCHED_STALL_TIMEOUT_EN and STALL_TIMEOUT=10: ack held low → cpu_stall drops after 10 cycles, stall_timeout=1, no copy_start.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared constants and scheduler state encoding for the per-frame rectangle-table copy.
package rect_pkg;

   localparam int RECT_COUNT     = 64;
   localparam int WORDS_PER_RECT = 6;
   localparam int COPY_CYCLES    = RECT_COUNT * WORDS_PER_RECT;
   localparam int RECT_BASE      = 8192 - COPY_CYCLES;

   typedef enum logic [2:0] {
      IDLE,
      STALL,
      START,
      COPY,
      DONE
   } state_t;

endpackage

// File: rtl/rect_sched_edge_ovr.sv
// vsync rising-edge detector plus a saturating count of edges that arrive while a frame is in flight.
module rect_sched_edge_ovr #(
   parameter int OVR_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 vsync,
   input  logic                 busy,
   output logic                 vs_edge,
   output logic [OVR_WIDTH-1:0] overrun_cnt
);

   logic vs_q;

   assign vs_edge = vsync & ~vs_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_q        <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         vs_q <= vsync;
         if (vs_edge && busy && (overrun_cnt != '1)) begin
            overrun_cnt <= overrun_cnt + OVR_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/rect_frame_scheduler.sv
// Per-vsync CPU stall / copier handoff with GPU rect-RAM write sequencing.
// Optional ack-wait timeout enabled by defining RECT_SCHED_STALL_TIMEOUT_EN.
module rect_frame_scheduler #(
   parameter int ADDR_WIDTH     = 13,
   parameter int RECT_COUNT     = rect_pkg::RECT_COUNT,
   parameter int WORDS_PER_RECT = rect_pkg::WORDS_PER_RECT,
   parameter int GPU_ADDR_WIDTH = 9,
   parameter int OVR_WIDTH      = 8,
   parameter int STALL_TIMEOUT  = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sched_en,
   input  logic                      vsync,
   output logic                      cpu_stall,
   input  logic                      cpu_stall_ack,
   input  logic [ADDR_WIDTH-1:0]     cpu_rd_addr,
   input  logic [ADDR_WIDTH-1:0]     copier_rd_addr,
   output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
   output logic                      copy_start,
   output logic                      gpu_we,
   output logic [GPU_ADDR_WIDTH-1:0] gpu_waddr,
   output logic                      busy,
   output logic                      frame_done,
   output logic [OVR_WIDTH-1:0]      overrun_cnt,
   output logic                      stall_timeout
);

   import rect_pkg::*;

   localparam logic [GPU_ADDR_WIDTH-1:0] LAST_ADDR =
      GPU_ADDR_WIDTH'(RECT_COUNT * WORDS_PER_RECT - 1);

   if ((STALL_TIMEOUT < 1) || (RECT_COUNT * WORDS_PER_RECT > (1 << GPU_ADDR_WIDTH))) begin : g_cfg_err
      $error("rect_frame_scheduler: STALL_TIMEOUT must be >= 1 and GPU_ADDR_WIDTH must hold the copy length");
   end

   state_t                    state;
   logic                      grant;
   logic                      vs_edge;
   logic [GPU_ADDR_WIDTH-1:0] cnt;

   rect_sched_edge_ovr #(
      .OVR_WIDTH (OVR_WIDTH)
   ) u_edge_ovr (
      .clk         (clk),
      .reset       (reset),
      .vsync       (vsync),
      .busy        (busy),
      .vs_edge     (vs_edge),
      .overrun_cnt (overrun_cnt)
   );

   assign busy        = (state != IDLE);
   assign gpu_waddr   = cnt;
   assign mem_rd_addr = grant ? copier_rd_addr : cpu_rd_addr;

`ifdef RECT_SCHED_STALL_TIMEOUT_EN
   localparam int WAIT_W = $clog2(STALL_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STALL_TIMEOUT - 1);
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_q;
   assign stall_timeout = timeout_q;
`else
   assign stall_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cpu_stall  <= 1'b0;
         copy_start <= 1'b0;
         grant      <= 1'b0;
         gpu_we     <= 1'b0;
         frame_done <= 1'b0;
         cnt        <= '0;
`ifdef RECT_SCHED_STALL_TIMEOUT_EN
         wait_cnt   <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         copy_start <= 1'b0;
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (vs_edge && sched_en) begin
                  state     <= STALL;
                  cpu_stall <= 1'b1;
`ifdef RECT_SCHED_STALL_TIMEOUT_EN
                  wait_cnt  <= '0;
`endif
               end
            end
            STALL: begin
               if (cpu_stall_ack) begin
                  state      <= START;
                  copy_start <= 1'b1;
                  grant      <= 1'b1;
                  cnt        <= '0;
               end
`ifdef RECT_SCHED_STALL_TIMEOUT_EN
               else if (wait_cnt == WAIT_LAST) begin
                  // CPU never froze: give up on this frame and flag it until reset.
                  state     <= IDLE;
                  cpu_stall <= 1'b0;
                  timeout_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
`endif
            end
            START: begin
               state  <= COPY;
               gpu_we <= 1'b1;
            end
            COPY: begin
               if (cnt == LAST_ADDR) begin
                  // Release the port and the CPU together so the CPU never sees the copier address.
                  state      <= DONE;
                  gpu_we     <= 1'b0;
                  grant      <= 1'b0;
                  cpu_stall  <= 1'b0;
                  frame_done <= 1'b1;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt + GPU_ADDR_WIDTH'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rect_frame_scheduler.sv
// Directed, table-driven bench for rect_frame_scheduler with hand-written multi-cycle sequences.
module tb_rect_frame_scheduler;

   import rect_pkg::*;

   localparam logic [12:0] CPU_A = 13'h0100;
   localparam logic [12:0] COP_A = 13'(RECT_BASE);

   logic        clk = 1'b0;
   logic        reset;
   logic        sched_en;
   logic        vsync;
   logic        cpu_stall;
   logic        cpu_stall_ack;
   logic [12:0] cpu_rd_addr;
   logic [12:0] copier_rd_addr;
   logic [12:0] mem_rd_addr;
   logic        copy_start;
   logic        gpu_we;
   logic [8:0]  gpu_waddr;
   logic        busy;
   logic        frame_done;
   logic [7:0]  overrun_cnt;
   logic        stall_timeout;

   int errors = 0;
   int checks = 0;

   rect_frame_scheduler #(
      .ADDR_WIDTH     (13),
      .RECT_COUNT     (64),
      .WORDS_PER_RECT (6),
      .GPU_ADDR_WIDTH (9),
      .OVR_WIDTH      (8),
      .STALL_TIMEOUT  (10)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .sched_en       (sched_en),
      .vsync          (vsync),
      .cpu_stall      (cpu_stall),
      .cpu_stall_ack  (cpu_stall_ack),
      .cpu_rd_addr    (cpu_rd_addr),
      .copier_rd_addr (copier_rd_addr),
      .mem_rd_addr    (mem_rd_addr),
      .copy_start     (copy_start),
      .gpu_we         (gpu_we),
      .gpu_waddr      (gpu_waddr),
      .busy           (busy),
      .frame_done     (frame_done),
      .overrun_cnt    (overrun_cnt),
      .stall_timeout  (stall_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        vs;
      logic        ack;
      logic        stall;
      logic        start;
      logic        we;
      logic [8:0]  waddr;
      logic        bsy;
      logic        done;
      logic [12:0] mem;
      logic [7:0]  ovr;
   } vec_t;

   vec_t vecs[15];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Raise vsync from IDLE, wait for cpu_stall, ack after ack_delay cycles, expect copy_start next.
   task automatic start_frame(input int ack_delay);
      int n;
      sched_en = 1'b1;
      vsync    = 1'b0;
      step();
      vsync = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!cpu_stall && n < 10);
      check("stall_seen", 32'(cpu_stall), 32'd1);
      repeat (ack_delay) step();
      cpu_stall_ack = 1'b1;
      step();
      check("copy_start", 32'(copy_start), 32'd1);
      check("start_mux", 32'(mem_rd_addr), 32'(COP_A));
      cpu_stall_ack = 1'b0;
      vsync = 1'b0;
   endtask

   // From the START cycle, run to frame_done and verify the full write burst.
   task automatic finish_frame();
      int          n_we;
      int          bad;
      int          n;
      logic [8:0]  exp_a;
      logic        seen;
      n_we  = 0;
      bad   = 0;
      n     = 0;
      exp_a = '0;
      seen  = 1'b0;
      while (!seen && n < 1000) begin
         step();
         n++;
         if (gpu_we) begin
            if (gpu_waddr !== exp_a) bad++;
            exp_a = exp_a + 9'd1;
            n_we++;
         end
         if (frame_done) seen = 1'b1;
      end
      check("frame_done_seen", 32'(seen), 32'd1);
      check("we_cycles", 32'(n_we), 32'(COPY_CYCLES));
      check("waddr_order_bad", 32'(bad), 32'd0);
      check("stall_released", 32'(cpu_stall), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      int n;
      int edges;
      int exp_ovr;

      //            en    vs    ack   stall start we    waddr  bsy   done  mem    ovr
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, CPU_A, 8'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, CPU_A, 8'd0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, CPU_A, 8'd0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, CPU_A, 8'd0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, CPU_A, 8'd0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, CPU_A, 8'd0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, CPU_A, 8'd0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 1'b1, 1'b0, COP_A, 8'd0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 1'b1, 1'b0, COP_A, 8'd0};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'd1, 1'b1, 1'b0, COP_A, 8'd1};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd2, 1'b1, 1'b0, COP_A, 8'd1};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'd3, 1'b1, 1'b0, COP_A, 8'd2};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd4, 1'b1, 1'b0, COP_A, 8'd2};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'd5, 1'b1, 1'b0, COP_A, 8'd3};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd6, 1'b1, 1'b0, COP_A, 8'd3};

      reset          = 1'b0;
      sched_en       = 1'b0;
      vsync          = 1'b0;
      cpu_stall_ack  = 1'b0;
      cpu_rd_addr    = CPU_A;
      copier_rd_addr = COP_A;
      #12;
      check("rst_stall", 32'(cpu_stall), 32'd0);
      check("rst_start", 32'(copy_start), 32'd0);
      check("rst_we", 32'(gpu_we), 32'd0);
      check("rst_waddr", 32'(gpu_waddr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_ovr", 32'(overrun_cnt), 32'd0);
      check("rst_mux", 32'(mem_rd_addr), 32'(CPU_A));
      step();
      reset = 1'b1;
      step();

      // Table: disabled edge, frame entry, 3-cycle ack, START, first COPY words, overruns.
      for (int i = 0; i < 15; i++) begin
         sched_en      = vecs[i].en;
         vsync         = vecs[i].vs;
         cpu_stall_ack = vecs[i].ack;
         step();
         check($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].stall));
         check($sformatf("v%0d_start", i), 32'(copy_start), 32'(vecs[i].start));
         check($sformatf("v%0d_we", i), 32'(gpu_we), 32'(vecs[i].we));
         check($sformatf("v%0d_waddr", i), 32'(gpu_waddr), 32'(vecs[i].waddr));
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
         check($sformatf("v%0d_done", i), 32'(frame_done), 32'(vecs[i].done));
         check($sformatf("v%0d_mux", i), 32'(mem_rd_addr), 32'(vecs[i].mem));
         check($sformatf("v%0d_ovr", i), 32'(overrun_cnt), 32'(vecs[i].ovr));
      end

      // Rest of the frame; sched_en drops at word 100 and the frame must still finish.
      bad = 0;
      for (int k = 7; k < COPY_CYCLES; k++) begin
         step();
         if (!gpu_we || (gpu_waddr !== 9'(k)) || frame_done || (mem_rd_addr !== COP_A)) bad++;
         if (gpu_waddr == 9'd100) sched_en = 1'b0;
      end
      check("copy_words_bad", 32'(bad), 32'd0);
      check("last_waddr", 32'(gpu_waddr), 32'd383);
      check("en_dropped", 32'(sched_en), 32'd0);
      sched_en = 1'b1;
      step();
      check("done_pulse", 32'(frame_done), 32'd1);
      check("done_stall", 32'(cpu_stall), 32'd0);
      check("done_we", 32'(gpu_we), 32'd0);
      check("done_busy", 32'(busy), 32'd1);
      check("done_mux", 32'(mem_rd_addr), 32'(CPU_A));
      vsync = 1'b1;
      step();
      check("done_edge_ovr", 32'(overrun_cnt), 32'd4);
      check("post_done_pulse", 32'(frame_done), 32'd0);
      check("post_done_busy", 32'(busy), 32'd0);
      step();
      check("no_extra_frame", 32'(cpu_stall), 32'd0);
      check("no_extra_busy", 32'(busy), 32'd0);
      vsync = 1'b0;
      step();

      // Asynchronous reset in the middle of COPY.
      start_frame(1);
      n = 0;
      while (!(gpu_we && gpu_waddr == 9'd50) && n < 200) begin
         step();
         n++;
      end
      check("reached_w50", 32'(gpu_waddr), 32'd50);
      #2;
      reset = 1'b0;
      #1;
      check("arst_stall", 32'(cpu_stall), 32'd0);
      check("arst_we", 32'(gpu_we), 32'd0);
      check("arst_waddr", 32'(gpu_waddr), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(frame_done), 32'd0);
      check("arst_mux", 32'(mem_rd_addr), 32'(CPU_A));
      check("arst_ovr", 32'(overrun_cnt), 32'd0);
      step();
      step();
      check("arst_hold_done", 32'(frame_done), 32'd0);
      reset = 1'b1;
      step();
      check("post_rst_done", 32'(frame_done), 32'd0);
      start_frame(0);
      finish_frame();

      // Overrun saturation: 150 edges per busy frame, two frames.
      step();
      step();
      edges = 0;
      for (int f = 0; f < 2; f++) begin
         start_frame(2);
         n = 0;
         while (!frame_done && n < 1000) begin
            if (gpu_we && gpu_waddr >= 9'd10 && gpu_waddr < 9'd310) begin
               if (!vsync) edges++;
               vsync = ~vsync;
            end
            step();
            n++;
         end
         vsync = 1'b0;
         check($sformatf("sat_frame%0d_done", f), 32'(frame_done), 32'd1);
         exp_ovr = (edges > 255) ? 255 : edges;
         check($sformatf("sat_frame%0d_ovr", f), 32'(overrun_cnt), 32'(exp_ovr));
         step();
         step();
      end

`ifdef RECT_SCHED_STALL_TIMEOUT_EN
      // Ack never arrives: stall held exactly STALL_TIMEOUT cycles, then sticky flag.
      begin
         int st_cycles;
         logic started;
         logic done_seen;
         st_cycles = 0;
         started   = 1'b0;
         done_seen = 1'b0;
         sched_en  = 1'b1;
         vsync     = 1'b1;
         step();
         n = 0;
         while (cpu_stall && n < 50) begin
            st_cycles++;
            if (copy_start) started = 1'b1;
            if (frame_done) done_seen = 1'b1;
            step();
            n++;
         end
         vsync = 1'b0;
         check("to_stall_cycles", 32'(st_cycles), 32'd10);
         check("to_flag", 32'(stall_timeout), 32'd1);
         check("to_no_start", 32'(started | copy_start), 32'd0);
         check("to_no_done", 32'(done_seen | frame_done), 32'd0);
         check("to_idle", 32'(busy), 32'd0);
         step();
         step();
         check("to_sticky", 32'(stall_timeout), 32'd1);
      end
`else
      check("stall_timeout_tied", 32'(stall_timeout), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
